// File: rtl/tube_sync_pkg.sv
// Shared constants for the single-clock Tube block.
// Control bit positions, register map, R3 geometry, reset FSM states.
package tube_sync_pkg;

    localparam int CTL_T = 6;
    localparam int CTL_P = 5;
    localparam int CTL_V = 4;
    localparam int CTL_M = 3;
    localparam int CTL_J = 2;
    localparam int CTL_I = 1;
    localparam int CTL_Q = 0;

    localparam logic [2:0] STAT1 = 3'd0;
    localparam logic [2:0] DATA1 = 3'd1;
    localparam logic [2:0] STAT2 = 3'd2;
    localparam logic [2:0] DATA2 = 3'd3;
    localparam logic [2:0] STAT3 = 3'd4;
    localparam logic [2:0] DATA3 = 3'd5;
    localparam logic [2:0] STAT4 = 3'd6;
    localparam logic [2:0] DATA4 = 3'd7;

    localparam logic [6:0] CTRL_RESET = 7'b0000001;

    localparam int R3_PHYS_DEPTH = 2;

    typedef enum logic [1:0] {
        RST_IDLE,
        RST_HOLD,
        RST_PULSE
    } rst_state_t;

endpackage

// File: rtl/tube_sync_if.sv
// Register-bus bundle used by both the host and the parasite side.
// master = bus logic outside the block, slave = tube_sync.
interface tube_sync_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cs, rd, wr, addr, wdata, input rdata);
    modport slave  (input cs, rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/tube_sync_fifo.sv
// Byte FIFO with run-time capacity limit and flush to reset contents.
// An empty FIFO presents the last byte popped (stale read).
module tube_sync_fifo #(
    parameter int         DEPTH       = 1,
    parameter int         CW          = $clog2(DEPTH + 1),
    parameter int         RESET_COUNT = 0,
    parameter logic [7:0] RESET_DATA  = 8'h00
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    input  logic [CW-1:0] capacity,
    output logic [7:0]    dout,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] WR_RST  = PW'(RESET_COUNT % DEPTH);
    localparam logic [CW-1:0] CNT_RST = CW'(RESET_COUNT);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    last;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO still lands when a real pop frees the slot.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < capacity) || do_pop);
        dout    = (count != '0) ? mem[rd_ptr] : last;
    end

    // Storage, pointers and occupancy; flush dominates all traffic.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_DATA;
            rd_ptr <= '0;
            wr_ptr <= WR_RST;
            count  <= CNT_RST;
            last   <= RESET_DATA;
        end else if (flush) begin
            mem[0] <= RESET_DATA;
            rd_ptr <= '0;
            wr_ptr <= WR_RST;
            count  <= CNT_RST;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) begin
                last   <= mem[rd_ptr];
                rd_ptr <= inc(rd_ptr);
            end
            if (do_push && !do_pop) count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/tube_sync.sv
// Tube host/parasite interface: four byte channels each way,
// control/status registers, parasite interrupts and reset pulse.
module tube_sync
    import tube_sync_pkg::*;
#(
    parameter int PH1_DEPTH  = 24,
    parameter int HP1_DEPTH  = 1,
    parameter int R24_DEPTH  = 1,
    parameter int RST_CYCLES = 160
) (
    input  logic        clk,
    input  logic        rst_b,
    tube_sync_if.slave  h_bus,
    tube_sync_if.slave  p_bus,
    output logic        h_irq,
    output logic        p_nmi,
    output logic        p_irq,
    output logic        p_rst_b
);
    localparam int MAXA = (PH1_DEPTH > HP1_DEPTH) ? PH1_DEPTH : HP1_DEPTH;
    localparam int MAXB = (R24_DEPTH > R3_PHYS_DEPTH) ? R24_DEPTH : R3_PHYS_DEPTH;
    localparam int MAXD = (MAXA > MAXB) ? MAXA : MAXB;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int RCW  = $clog2(RST_CYCLES + 1);
    localparam int LOAD = (RST_CYCLES > 1) ? RST_CYCLES - 2 : 0;

    logic [6:0]    ctrl;
    logic [CW-1:0] r3_cap;
    logic          h_rd_en, h_wr_en, p_rd_en, p_wr_en;
    logic [3:0]    hp_push, hp_pop, ph_push, ph_pop;
    logic [7:0]    hp_dout [4];
    logic [7:0]    ph_dout [4];
    logic [CW-1:0] hp_cnt  [4];
    logic [CW-1:0] ph_cnt  [4];
    logic [CW-1:0] hp_cap  [4];
    logic [CW-1:0] ph_cap  [4];
    logic [3:0]    hp_av, hp_nf, ph_av, ph_nf;
    logic          nmi_flag;
    logic [7:0]    h_rd_val, p_rd_val;
    logic [7:0]    h_rdata_q, p_rdata_q;
    rst_state_t    state, state_nxt;
    logic [RCW-1:0] rst_cnt, cnt_nxt;
    logic          prst_nxt;

    assign h_rd_en = h_bus.cs & h_bus.rd;
    assign h_wr_en = h_bus.cs & h_bus.wr;
    assign p_rd_en = p_bus.cs & p_bus.rd;
    assign p_wr_en = p_bus.cs & p_bus.wr;
    assign r3_cap  = ctrl[CTL_V] ? CW'(R3_PHYS_DEPTH) : CW'(1);
    assign nmi_flag = hp_av[2] | (ph_cnt[2] == '0);
    assign h_bus.rdata = h_rdata_q;
    assign p_bus.rdata = p_rdata_q;

    for (genvar n = 0; n < 4; n++) begin : g_ch
        localparam int HD = (n == 0) ? HP1_DEPTH :
                            (n == 2) ? R3_PHYS_DEPTH : R24_DEPTH;
        localparam int PD = (n == 0) ? PH1_DEPTH :
                            (n == 2) ? R3_PHYS_DEPTH : R24_DEPTH;
        localparam int PRC = (n == 2) ? 1 : 0;

        assign hp_push[n] = h_wr_en & h_bus.addr[0] & (h_bus.addr[2:1] == 2'(n));
        assign ph_pop[n]  = h_rd_en & h_bus.addr[0] & (h_bus.addr[2:1] == 2'(n));
        assign ph_push[n] = p_wr_en & p_bus.addr[0] & (p_bus.addr[2:1] == 2'(n));
        assign hp_pop[n]  = p_rd_en & p_bus.addr[0] & (p_bus.addr[2:1] == 2'(n));
        assign hp_cap[n]  = (n == 2) ? r3_cap : CW'(HD);
        assign ph_cap[n]  = (n == 2) ? r3_cap : CW'(PD);

        // R3 is "available" only once it holds a full capacity's worth.
        assign hp_av[n] = (n == 2) ? (hp_cnt[n] >= hp_cap[n])
                                   : (hp_cnt[n] != '0);
        assign ph_av[n] = (ph_cnt[n] != '0);
        assign hp_nf[n] = (hp_cnt[n] < hp_cap[n]);
        assign ph_nf[n] = (ph_cnt[n] < ph_cap[n]);

        tube_sync_fifo #(
            .DEPTH(HD), .CW(CW), .RESET_COUNT(0), .RESET_DATA(8'h00)
        ) u_hp (
            .clk(clk), .rst_b(rst_b),
            .push(hp_push[n]), .pop(hp_pop[n]), .flush(ctrl[CTL_T]),
            .din(h_bus.wdata), .capacity(hp_cap[n]),
            .dout(hp_dout[n]), .count(hp_cnt[n])
        );

        tube_sync_fifo #(
            .DEPTH(PD), .CW(CW), .RESET_COUNT(PRC), .RESET_DATA(8'h00)
        ) u_ph (
            .clk(clk), .rst_b(rst_b),
            .push(ph_push[n]), .pop(ph_pop[n]), .flush(ctrl[CTL_T]),
            .din(p_bus.wdata), .capacity(ph_cap[n]),
            .dout(ph_dout[n]), .count(ph_cnt[n])
        );
    end

    // Host-side read mux.
    always_comb begin
        h_rd_val = '0;
        unique case (h_bus.addr)
            STAT1: h_rd_val = {ph_av[0], hp_nf[0], ctrl[5:0]};
            DATA1: h_rd_val = ph_dout[0];
            STAT2: h_rd_val = {ph_av[1], hp_nf[1], 6'h3F};
            DATA2: h_rd_val = ph_dout[1];
            STAT3: h_rd_val = {ph_av[2], hp_nf[2], 6'h3F};
            DATA3: h_rd_val = ph_dout[2];
            STAT4: h_rd_val = {ph_av[3], hp_nf[3], 6'h3F};
            DATA4: h_rd_val = ph_dout[3];
            default: h_rd_val = '0;
        endcase
    end

    // Parasite-side read mux; R3 status bit 7 doubles as the NMI flag.
    always_comb begin
        p_rd_val = '0;
        unique case (p_bus.addr)
            STAT1: p_rd_val = {hp_av[0], ph_nf[0], ctrl[5:0]};
            DATA1: p_rd_val = hp_dout[0];
            STAT2: p_rd_val = {hp_av[1], ph_nf[1], 6'h3F};
            DATA2: p_rd_val = hp_dout[1];
            STAT3: p_rd_val = {nmi_flag, ph_nf[2], 6'h3F};
            DATA3: p_rd_val = hp_dout[2];
            STAT4: p_rd_val = {hp_av[3], ph_nf[3], 6'h3F};
            DATA4: p_rd_val = hp_dout[3];
            default: p_rd_val = '0;
        endcase
    end

    // Control register: host bit 7 selects set or clear of bits 6..0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) ctrl <= CTRL_RESET;
        else if (h_wr_en && h_bus.addr == STAT1)
            ctrl <= h_bus.wdata[7] ? (ctrl | h_bus.wdata[6:0])
                                   : (ctrl & ~h_bus.wdata[6:0]);
    end

    // Registered read data and interrupt requests.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            h_rdata_q <= '0;
            p_rdata_q <= '0;
            h_irq     <= 1'b0;
            p_nmi     <= 1'b0;
            p_irq     <= 1'b0;
        end else begin
            if (h_rd_en) h_rdata_q <= h_rd_val;
            if (p_rd_en) p_rdata_q <= p_rd_val;
            h_irq <= ctrl[CTL_Q] & ph_av[3];
            p_nmi <= ctrl[CTL_M] & nmi_flag;
            p_irq <= (ctrl[CTL_I] & hp_av[0]) | (ctrl[CTL_J] & hp_av[3]);
        end
    end

    // Parasite reset FSM state, pulse counter and output register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= RST_IDLE;
            rst_cnt <= '0;
            p_rst_b <= 1'b0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= cnt_nxt;
            p_rst_b <= prst_nxt;
        end
    end

    // Hold reset while P is set, then time RST_CYCLES after P falls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = rst_cnt;
        prst_nxt  = p_rst_b;
        unique case (state)
            RST_IDLE: begin
                prst_nxt = ~ctrl[CTL_P];
                if (ctrl[CTL_P]) state_nxt = RST_HOLD;
            end
            RST_HOLD: begin
                prst_nxt = 1'b0;
                if (!ctrl[CTL_P]) begin
                    if (RST_CYCLES > 1) begin
                        state_nxt = RST_PULSE;
                        cnt_nxt   = RCW'(LOAD);
                    end else begin
                        state_nxt = RST_IDLE;
                        prst_nxt  = 1'b1;
                    end
                end
            end
            RST_PULSE: begin
                prst_nxt = 1'b0;
                if (ctrl[CTL_P]) begin
                    state_nxt = RST_HOLD;
                end else if (rst_cnt == '0) begin
                    state_nxt = RST_IDLE;
                    prst_nxt  = 1'b1;
                end else begin
                    cnt_nxt = rst_cnt - RCW'(1);
                end
            end
            default: state_nxt = RST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tube_sync.sv
// Directed bench for tube_sync: register table plus
// hand sequences for FIFO depth, interrupts and reset pulse.
module tb_tube_sync;
    localparam int RSTC = 160;

    typedef struct {
        bit         host;
        bit         cs;
        bit         rd;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] wd;
        bit         chk;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic h_irq, p_nmi, p_irq, p_rst_b;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t vt [$];

    tube_sync_if h_bus ();
    tube_sync_if p_bus ();

    tube_sync #(
        .PH1_DEPTH(24), .HP1_DEPTH(1), .R24_DEPTH(1), .RST_CYCLES(RSTC)
    ) dut (
        .clk(clk), .rst_b(rst_b), .h_bus(h_bus), .p_bus(p_bus),
        .h_irq(h_irq), .p_nmi(p_nmi), .p_irq(p_irq), .p_rst_b(p_rst_b)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check1(string nm, logic act, logic exp);
        check(nm, {7'b0, act}, {7'b0, exp});
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic h_acc(bit rd, bit wr, logic [2:0] a, logic [7:0] d, bit cs = 1);
        h_bus.cs = cs; h_bus.rd = rd; h_bus.wr = wr;
        h_bus.addr = a; h_bus.wdata = d;
        idle(1);
        h_bus.cs = 0; h_bus.rd = 0; h_bus.wr = 0;
    endtask

    task automatic p_acc(bit rd, bit wr, logic [2:0] a, logic [7:0] d, bit cs = 1);
        p_bus.cs = cs; p_bus.rd = rd; p_bus.wr = wr;
        p_bus.addr = a; p_bus.wdata = d;
        idle(1);
        p_bus.cs = 0; p_bus.rd = 0; p_bus.wr = 0;
    endtask

    function automatic vec_t mk(bit host, bit cs, bit rd, bit wr,
                                logic [2:0] a, logic [7:0] d,
                                bit chk, logic [7:0] exp, string nm);
        vec_t v;
        v.host = host; v.cs = cs; v.rd = rd; v.wr = wr;
        v.addr = a; v.wd = d; v.chk = chk; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    initial begin
        bit low_ok;
        h_bus.cs = 0; h_bus.rd = 0; h_bus.wr = 0; h_bus.addr = 0; h_bus.wdata = 0;
        p_bus.cs = 0; p_bus.rd = 0; p_bus.wr = 0; p_bus.addr = 0; p_bus.wdata = 0;

        vt.push_back(mk(1, 1, 1, 0, 3'd0, 8'h00, 1, 8'h41, "h_ctl_rst"));
        vt.push_back(mk(1, 1, 0, 1, 3'd0, 8'hC0, 0, 8'h00, "set_t"));
        vt.push_back(mk(1, 1, 0, 1, 3'd0, 8'h40, 0, 8'h00, "clr_t"));
        vt.push_back(mk(0, 1, 1, 0, 3'd4, 8'h00, 1, 8'h3F, "p_st3_full"));
        vt.push_back(mk(1, 1, 1, 0, 3'd5, 8'h00, 1, 8'h00, "h_ph3_rst"));
        vt.push_back(mk(0, 1, 1, 0, 3'd4, 8'h00, 1, 8'hFF, "p_st3_empty"));
        vt.push_back(mk(1, 1, 1, 0, 3'd2, 8'h00, 1, 8'h7F, "h_st2"));
        vt.push_back(mk(0, 1, 1, 0, 3'd0, 8'h00, 1, 8'h41, "p_st1"));
        vt.push_back(mk(0, 1, 0, 1, 3'd0, 8'hFF, 0, 8'h00, "p_ctl_wr"));
        vt.push_back(mk(1, 1, 1, 0, 3'd0, 8'h00, 1, 8'h41, "p_ctl_ign"));
        vt.push_back(mk(0, 0, 0, 1, 3'd1, 8'h77, 0, 8'h00, "cs0_wr"));
        vt.push_back(mk(1, 1, 1, 0, 3'd0, 8'h00, 1, 8'h41, "cs0_ign"));
        vt.push_back(mk(1, 1, 0, 1, 3'd3, 8'h12, 0, 8'h00, "hp2_wr"));
        vt.push_back(mk(0, 1, 1, 0, 3'd2, 8'h00, 1, 8'hFF, "p_st2_av"));
        vt.push_back(mk(0, 1, 1, 0, 3'd3, 8'h00, 1, 8'h12, "hp2_data"));
        vt.push_back(mk(0, 1, 1, 0, 3'd3, 8'h00, 1, 8'h12, "hp2_stale"));
        vt.push_back(mk(0, 1, 1, 0, 3'd2, 8'h00, 1, 8'h7F, "p_st2_empty"));
        vt.push_back(mk(1, 1, 0, 1, 3'd7, 8'h34, 0, 8'h00, "hp4_wr"));
        vt.push_back(mk(1, 1, 0, 1, 3'd7, 8'h56, 0, 8'h00, "hp4_wr_full"));
        vt.push_back(mk(0, 1, 1, 0, 3'd7, 8'h00, 1, 8'h34, "hp4_data"));
        vt.push_back(mk(0, 1, 1, 0, 3'd6, 8'h00, 1, 8'h7F, "hp4_drop"));
        vt.push_back(mk(0, 1, 1, 0, 3'd7, 8'h00, 1, 8'h34, "hp4_stale"));
        vt.push_back(mk(1, 1, 1, 1, 3'd0, 8'h84, 1, 8'h41, "rdwr_pre"));
        vt.push_back(mk(1, 1, 1, 0, 3'd0, 8'h00, 1, 8'h45, "ctl_setj"));
        vt.push_back(mk(1, 1, 0, 1, 3'd0, 8'h04, 0, 8'h00, "clr_j"));
        vt.push_back(mk(1, 1, 1, 0, 3'd0, 8'h00, 1, 8'h41, "ctl_clrj"));

        repeat (3) @(posedge clk);
        #1;
        check1("rst_prst", p_rst_b, 1'b0);
        check("rst_hrdata", h_bus.rdata, 8'h00);
        check1("rst_pnmi", p_nmi, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        idle(1);
        check1("prst_run", p_rst_b, 1'b1);

        foreach (vt[i]) begin
            if (vt[i].host) h_acc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].cs);
            else p_acc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].cs);
            if (vt[i].chk)
                check(vt[i].nm, vt[i].host ? h_bus.rdata : p_bus.rdata, vt[i].exp);
        end

        for (int i = 1; i <= 24; i++) p_acc(0, 1, 3'd1, 8'(i));
        p_acc(1, 0, 3'd0, 8'h00);
        check("p_ph1_full", p_bus.rdata, 8'h01);
        h_acc(1, 0, 3'd0, 8'h00);
        check("h_ph1_av", h_bus.rdata, 8'hC1);
        p_acc(0, 1, 3'd1, 8'hFF);
        for (int i = 1; i <= 24; i++) begin
            h_acc(1, 0, 3'd1, 8'h00);
            check($sformatf("ph1_rd%0d", i), h_bus.rdata, 8'(i));
        end
        h_acc(1, 0, 3'd1, 8'h00);
        check("ph1_stale", h_bus.rdata, 8'h18);
        h_acc(1, 0, 3'd0, 8'h00);
        check("h_ph1_empty", h_bus.rdata, 8'h41);

        p_acc(0, 1, 3'd7, 8'h5A);
        idle(1);
        check1("h_irq_set", h_irq, 1'b1);
        h_acc(1, 0, 3'd7, 8'h00);
        check("ph4_data", h_bus.rdata, 8'h5A);
        idle(1);
        check1("h_irq_clr", h_irq, 1'b0);

        h_acc(0, 1, 3'd0, 8'hC0);
        h_acc(0, 1, 3'd0, 8'h40);
        h_acc(0, 1, 3'd0, 8'h90);
        h_acc(0, 1, 3'd0, 8'h88);
        h_acc(0, 1, 3'd5, 8'hAA);
        idle(2);
        check1("nmi_one_byte", p_nmi, 1'b0);
        h_acc(0, 1, 3'd5, 8'hBB);
        idle(1);
        check1("nmi_two_byte", p_nmi, 1'b1);
        p_acc(1, 0, 3'd5, 8'h00);
        check("hp3_rd_a", p_bus.rdata, 8'hAA);
        p_acc(1, 0, 3'd5, 8'h00);
        check("hp3_rd_b", p_bus.rdata, 8'hBB);
        idle(1);
        check1("nmi_clr", p_nmi, 1'b0);
        h_acc(0, 1, 3'd0, 8'h08);

        h_acc(0, 1, 3'd0, 8'h82);
        h_acc(0, 1, 3'd1, 8'h55);
        idle(1);
        check1("irq_set", p_irq, 1'b1);
        h_bus.cs = 1; h_bus.wr = 1; h_bus.addr = 3'd1; h_bus.wdata = 8'h66;
        p_bus.cs = 1; p_bus.rd = 1; p_bus.addr = 3'd1;
        idle(1);
        h_bus.cs = 0; h_bus.wr = 0; p_bus.cs = 0; p_bus.rd = 0;
        check("hp1_pushpop", p_bus.rdata, 8'h55);
        idle(1);
        check1("irq_hold", p_irq, 1'b1);
        p_acc(1, 0, 3'd1, 8'h00);
        check("hp1_second", p_bus.rdata, 8'h66);
        idle(1);
        check1("irq_clr", p_irq, 1'b0);

        h_acc(0, 1, 3'd0, 8'hA0);
        idle(2);
        check1("prst_p_set", p_rst_b, 1'b0);
        h_acc(0, 1, 3'd0, 8'h20);
        low_ok = 1'b1;
        for (int k = 1; k < RSTC; k++) begin
            idle(1);
            if (p_rst_b !== 1'b0) low_ok = 1'b0;
        end
        check1("prst_low", low_ok, 1'b1);
        idle(1);
        check1("prst_rise", p_rst_b, 1'b1);

        h_acc(0, 1, 3'd0, 8'hA0);
        idle(2);
        h_acc(0, 1, 3'd0, 8'h20);
        idle(50);
        h_acc(0, 1, 3'd0, 8'hA0);
        idle(150);
        check1("prst_hold", p_rst_b, 1'b0);
        h_acc(0, 1, 3'd0, 8'h20);
        idle(RSTC - 1);
        check1("prst_restart_low", p_rst_b, 1'b0);
        idle(1);
        check1("prst_restart_rise", p_rst_b, 1'b1);

        h_acc(0, 1, 3'd1, 8'h99);
        h_acc(0, 1, 3'd0, 8'h84);
        h_acc(0, 1, 3'd7, 8'h3C);
        p_acc(0, 1, 3'd7, 8'h11);
        h_acc(0, 1, 3'd0, 8'hA0);
        h_acc(0, 1, 3'd0, 8'h20);
        idle(10);
        p_acc(1, 0, 3'd1, 8'h00);
        check("p_pre_rst", p_bus.rdata, 8'h99);
        h_acc(1, 0, 3'd0, 8'h00);
        check("h_pre_rst", h_bus.rdata, 8'h57);
        check1("pirq_pre_rst", p_irq, 1'b1);
        check1("hirq_pre_rst", h_irq, 1'b1);
        check1("prst_pre_rst", p_rst_b, 1'b0);
        #3;
        rst_b = 1'b0;
        #1;
        check("arst_hrdata", h_bus.rdata, 8'h00);
        check("arst_prdata", p_bus.rdata, 8'h00);
        check1("arst_pirq", p_irq, 1'b0);
        check1("arst_hirq", h_irq, 1'b0);
        check1("arst_pnmi", p_nmi, 1'b0);
        check1("arst_prst", p_rst_b, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        idle(1);
        h_acc(1, 0, 3'd0, 8'h00);
        check("arst_ctl", h_bus.rdata, 8'h41);
        check1("arst_prst_run", p_rst_b, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
